// File: rtl/mine_pkg.sv
// Shared types and constants for the minesweeper game controller:
// FSM state encoding, cursor directions and the 8-neighbour offset table.
package mine_pkg;

  localparam int NUM_CELLS = 64;

  typedef enum logic [2:0] {
    IDLE, LOAD, PLAY, COUNT, CHECK, DRAW, RESEED, END
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Two's-complement row/column deltas, each in -1..+1.
  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } nb_off_t;

  // Neighbour scan order: NW, N, NE, W, E, SW, S, SE.
  function automatic nb_off_t nb_off(input logic [2:0] k);
    case (k)
      3'd0:    return '{dr: 2'b11, dc: 2'b11};
      3'd1:    return '{dr: 2'b11, dc: 2'b00};
      3'd2:    return '{dr: 2'b11, dc: 2'b01};
      3'd3:    return '{dr: 2'b00, dc: 2'b11};
      3'd4:    return '{dr: 2'b00, dc: 2'b01};
      3'd5:    return '{dr: 2'b01, dc: 2'b11};
      3'd6:    return '{dr: 2'b01, dc: 2'b00};
      default: return '{dr: 2'b01, dc: 2'b01};
    endcase
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse on the first cycle a level
// input is seen high after being low.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game-sequencing FSM: cursor, datapath load strobes, adjacent
// mine count, win/lose and renderer handshake. Optional feature macro:
// MINE_GAME_CTRL_SAFE_FIRST_STEP_EN (first step never lands on a mine).
module mine_game_ctrl
  import mine_pkg::*;
#(
  parameter int SIDE_LOG2    = 3,
  parameter int DRAW_TIMEOUT = 4095,
  parameter int RESEED_MAX   = 15,
  localparam int CELLS = 1 << (2 * SIDE_LOG2),
  localparam int IDX_W = 2 * SIDE_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             btn_flag,
  input  logic             btn_step,
  input  logic             btn_move,
  input  logic [1:0]       dir,
  input  logic [CELLS-1:0] mine_map,
  input  logic [CELLS-1:0] flag_map,
  input  logic [CELLS-1:0] step_map,
  input  logic             draw_done,
  output logic             ld_mm,
  output logic             ld_fm,
  output logic             ld_sm,
  output logic [IDX_W-1:0] cell_idx,
  output logic [3:0]       adj_count,
  output logic             adj_valid,
  output logic             draw_req,
  output logic             win,
  output logic             lose
);

  localparam int DRAW_W   = $clog2(DRAW_TIMEOUT + 1);
  localparam int RESEED_W = $clog2(RESEED_MAX + 2);

  if (DRAW_TIMEOUT < 1 || RESEED_MAX < 0) begin : g_param_check
    $error("mine_game_ctrl: DRAW_TIMEOUT must be >= 1 and RESEED_MAX >= 0");
  end

  state_t                state, ret_state;
  logic [SIDE_LOG2-1:0]  cur_row, cur_col;
  logic [2:0]            nb_sel;
  logic [DRAW_W-1:0]     draw_cnt;
`ifdef MINE_GAME_CTRL_SAFE_FIRST_STEP_EN
  logic                  first_step;
  logic                  reseed_wait;
  logic [RESEED_W-1:0]   reseed_cnt;
`endif

  logic start_e, flag_e, step_e, move_e;

  edge_pulse u_ep_start (.clk(clk), .reset(reset), .level(start),    .pulse(start_e));
  edge_pulse u_ep_flag  (.clk(clk), .reset(reset), .level(btn_flag), .pulse(flag_e));
  edge_pulse u_ep_step  (.clk(clk), .reset(reset), .level(btn_step), .pulse(step_e));
  edge_pulse u_ep_move  (.clk(clk), .reset(reset), .level(btn_move), .pulse(move_e));

  assign cell_idx = {cur_row, cur_col};

  logic mine_here, flag_here, step_here, all_clear;
  assign mine_here = mine_map[cell_idx];
  assign flag_here = flag_map[cell_idx];
  assign step_here = step_map[cell_idx];
  assign all_clear = &(step_map | mine_map);

  // Neighbour coordinates carry two guard bits: any nonzero guard means the
  // neighbour fell off the board, so edges never wrap during the count.
  nb_off_t              off;
  logic [SIDE_LOG2+1:0] nb_r, nb_c;
  logic                 nb_mine;

  always_comb begin
    off     = nb_off(nb_sel);
    nb_r    = {2'b00, cur_row} + {{SIDE_LOG2{off.dr[1]}}, off.dr};
    nb_c    = {2'b00, cur_col} + {{SIDE_LOG2{off.dc[1]}}, off.dc};
    nb_mine = 1'b0;
    if (nb_r[SIDE_LOG2+1:SIDE_LOG2] == 2'b00 && nb_c[SIDE_LOG2+1:SIDE_LOG2] == 2'b00)
      nb_mine = mine_map[{nb_r[SIDE_LOG2-1:0], nb_c[SIDE_LOG2-1:0]}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= PLAY;
      cur_row   <= '0;
      cur_col   <= '0;
      nb_sel    <= '0;
      draw_cnt  <= '0;
      ld_mm     <= 1'b0;
      ld_fm     <= 1'b0;
      ld_sm     <= 1'b0;
      adj_count <= '0;
      adj_valid <= 1'b0;
      draw_req  <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
`ifdef MINE_GAME_CTRL_SAFE_FIRST_STEP_EN
      first_step  <= 1'b0;
      reseed_wait <= 1'b0;
      reseed_cnt  <= '0;
`endif
    end else begin
      // NOTE: strobes default low so every load pulse lasts exactly one cycle.
      ld_mm <= 1'b0;
      ld_fm <= 1'b0;
      ld_sm <= 1'b0;

      case (state)
        IDLE, END: begin
          if (start_e) begin
            win       <= 1'b0;
            lose      <= 1'b0;
            adj_valid <= 1'b0;
            cur_row   <= '0;
            cur_col   <= '0;
            state     <= LOAD;
`ifdef MINE_GAME_CTRL_SAFE_FIRST_STEP_EN
            first_step <= 1'b1;
            reseed_cnt <= '0;
`endif
          end
        end

        LOAD: begin
          ld_mm     <= 1'b1;
          draw_req  <= 1'b1;
          ret_state <= PLAY;
          state     <= DRAW;
        end

        PLAY: begin
          if (step_e) begin
            if (!flag_here && !step_here) begin
              ld_sm     <= 1'b1;
              adj_valid <= 1'b0;
              adj_count <= '0;
              nb_sel    <= '0;
              state     <= COUNT;
            end
          end else if (flag_e) begin
            if (!step_here) begin
              ld_fm     <= 1'b1;
              draw_req  <= 1'b1;
              ret_state <= PLAY;
              state     <= DRAW;
            end
          end else if (move_e) begin
            case (dir)
              DIR_UP:    cur_row <= cur_row - 1'b1;
              DIR_RIGHT: cur_col <= cur_col + 1'b1;
              DIR_DOWN:  cur_row <= cur_row + 1'b1;
              default:   cur_col <= cur_col - 1'b1;
            endcase
            draw_req  <= 1'b1;
            ret_state <= PLAY;
            state     <= DRAW;
          end
        end

        COUNT: begin
          adj_count <= adj_count + {3'b000, nb_mine};
          nb_sel    <= nb_sel + 3'd1;
          if (nb_sel == 3'd7) state <= CHECK;
        end

        CHECK: begin
          adj_valid <= 1'b1;
          draw_req  <= 1'b1;
          state     <= DRAW;
`ifdef MINE_GAME_CTRL_SAFE_FIRST_STEP_EN
          first_step <= 1'b0;
          if (first_step && mine_here && reseed_cnt < RESEED_W'(RESEED_MAX)) begin
            adj_valid   <= 1'b0;
            draw_req    <= 1'b0;
            ld_mm       <= 1'b1;
            reseed_cnt  <= reseed_cnt + 1'b1;
            reseed_wait <= 1'b1;
            state       <= RESEED;
          end else
`endif
          if (mine_here) begin
            lose      <= 1'b1;
            ret_state <= END;
          end else if (all_clear) begin
            win       <= 1'b1;
            ret_state <= END;
          end else begin
            ret_state <= PLAY;
          end
        end

`ifdef MINE_GAME_CTRL_SAFE_FIRST_STEP_EN
        // One idle cycle lets the datapath latch the new map before re-testing.
        RESEED: begin
          if (reseed_wait) begin
            reseed_wait <= 1'b0;
          end else if (mine_here) begin
            if (reseed_cnt < RESEED_W'(RESEED_MAX)) begin
              ld_mm       <= 1'b1;
              reseed_cnt  <= reseed_cnt + 1'b1;
              reseed_wait <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end else begin
            ld_sm     <= 1'b1;
            adj_count <= '0;
            nb_sel    <= '0;
            state     <= COUNT;
          end
        end
`endif

        DRAW: begin
          if (draw_done || draw_cnt == DRAW_W'(DRAW_TIMEOUT - 1)) begin
            draw_req <= 1'b0;
            draw_cnt <= '0;
            state    <= ret_state;
          end else begin
            draw_cnt <= draw_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Directed self-checking bench for mine_game_ctrl; the bench stands in for the
// map datapath by updating flag/step maps when it sees the load strobes.
module tb_mine_game_ctrl;
  import mine_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, btn_flag, btn_step, btn_move, draw_done;
  logic [1:0]  dir;
  logic [63:0] mine_map, flag_map, step_map;
  logic        ld_mm, ld_fm, ld_sm, adj_valid, draw_req, win, lose;
  logic [5:0]  cell_idx;
  logic [3:0]  adj_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_mm = 0, cnt_fm = 0, cnt_sm = 0, cnt_draw = 0;
  logic draw_q = 1'b0;

  always #5 clk = ~clk;

  mine_game_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .btn_flag(btn_flag),
    .btn_step(btn_step), .btn_move(btn_move), .dir(dir),
    .mine_map(mine_map), .flag_map(flag_map), .step_map(step_map),
    .draw_done(draw_done), .ld_mm(ld_mm), .ld_fm(ld_fm), .ld_sm(ld_sm),
    .cell_idx(cell_idx), .adj_count(adj_count), .adj_valid(adj_valid),
    .draw_req(draw_req), .win(win), .lose(lose)
  );

  // Strobe and redraw-request counters sampled on each active edge.
  always @(posedge clk) begin
    if (ld_mm) cnt_mm <= cnt_mm + 1;
    if (ld_fm) cnt_fm <= cnt_fm + 1;
    if (ld_sm) cnt_sm <= cnt_sm + 1;
    if (draw_req && !draw_q) cnt_draw <= cnt_draw + 1;
    draw_q <= draw_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic serve_draw(input string tag);
    int w = 0;
    while (draw_req !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_draw_req"}, draw_req, 1'b1);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  task automatic move(input logic [1:0] d);
    dir      = d;
    btn_move = 1'b1;
    tick();
    btn_move = 1'b0;
    serve_draw("move");
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_state_load"}, dut.state, LOAD);
    tick();
    check({tag, "_ld_mm_hi"}, ld_mm, 1'b1);
    tick();
    check({tag, "_ld_mm_lo"}, ld_mm, 1'b0);
    serve_draw(tag);
    check({tag, "_state_play"}, dut.state, PLAY);
    check({tag, "_cell0"}, cell_idx, 6'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, m0, f0, s0, n;
    reset = 1'b1; start = 1'b0; btn_flag = 1'b0; btn_step = 1'b0;
    btn_move = 1'b0; draw_done = 1'b0; dir = 2'd0;
    mine_map = 64'h0000_0000_0000_0505; flag_map = '0; step_map = '0;
    tick(3);
    check("rst_state", dut.state, IDLE);
    check("rst_outs", {ld_mm, ld_fm, ld_sm, adj_valid, draw_req, win, lose}, 7'd0);
    check("rst_cell", cell_idx, 6'd0);
    check("rst_adj", adj_count, 4'd0);
    reset = 1'b0;
    tick();

    m0 = cnt_mm;
    start_game("g1");
    check("g1_ld_mm_count", cnt_mm - m0, 1);

    // Cursor wraps: up from row 0 lands on row 7, left from col 0 on col 7.
    d0 = cnt_draw;
    move(DIR_UP);
    check("move_up", cell_idx, 6'd56);
    move(DIR_LEFT);
    check("move_left", cell_idx, 6'd63);
    check("move_draws", cnt_draw - d0, 2);

    // A held button acts once.
    d0 = cnt_draw;
    dir = DIR_RIGHT;
    btn_move = 1'b1;
    tick();
    serve_draw("hold");
    tick(100);
    btn_move = 1'b0;
    tick(3);
    check("hold_cell", cell_idx, 6'd56);
    check("hold_draws", cnt_draw - d0, 1);

    // Start edge in PLAY is ignored.
    m0 = cnt_mm;
    start = 1'b1;
    tick(3);
    start = 1'b0;
    tick();
    check("start_in_play_state", dut.state, PLAY);
    check("start_in_play_ld_mm", cnt_mm - m0, 0);

    // Step at (1,1): mines at 0,2,8,10 are all neighbours -> 4.
    move(DIR_DOWN);
    move(DIR_RIGHT);
    move(DIR_DOWN);
    check("cursor_9", cell_idx, 6'd9);
    s0 = cnt_sm;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check("step9_ld_sm", ld_sm, 1'b1);
    step_map[9] = 1'b1;
    tick(8);
    check("step9_valid_early", adj_valid, 1'b0);
    tick();
    check("step9_valid", adj_valid, 1'b1);
    check("step9_count", adj_count, 4'd4);
    check("step9_lose", lose, 1'b0);
    serve_draw("step9");
    check("step9_state", dut.state, PLAY);
    check("step9_sm_count", cnt_sm - s0, 1);

    // Step and flag in the same cycle: only the step acts. (2,1) sees 8 and 10.
    move(DIR_DOWN);
    f0 = cnt_fm;
    btn_step = 1'b1;
    btn_flag = 1'b1;
    tick();
    btn_step = 1'b0;
    btn_flag = 1'b0;
    check("prio_ld_sm", ld_sm, 1'b1);
    step_map[17] = 1'b1;
    tick(9);
    check("prio_count", adj_count, 4'd2);
    serve_draw("prio");
    check("prio_no_fm", cnt_fm - f0, 0);

    // Flag a cell, then a step on it is refused.
    move(DIR_DOWN);
    btn_flag = 1'b1;
    tick();
    btn_flag = 1'b0;
    check("flag_ld_fm", ld_fm, 1'b1);
    flag_map[25] = 1'b1;
    serve_draw("flag");
    s0 = cnt_sm;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick(3);
    check("flagged_no_sm", cnt_sm - s0, 0);
    check("flagged_state", dut.state, PLAY);

    // Renderer never answers: DRAW gives up after DRAW_TIMEOUT cycles.
    dir = DIR_RIGHT;
    btn_move = 1'b1;
    tick();
    btn_move = 1'b0;
    n = 0;
    while (draw_req === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 4095);
    check("timeout_state", dut.state, PLAY);
    check("timeout_cell", cell_idx, 6'd26);

    // Reset in the middle of COUNT.
    move(DIR_RIGHT);
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check("midcnt_ld_sm", ld_sm, 1'b1);
    step_map[27] = 1'b1;
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midcnt_state", dut.state, IDLE);
    check("midcnt_valid", adj_valid, 1'b0);
    check("midcnt_cell", cell_idx, 6'd0);
    m0 = cnt_mm; f0 = cnt_fm; s0 = cnt_sm;
    tick(12);
    check("midcnt_strobes", (cnt_mm - m0) + (cnt_fm - f0) + (cnt_sm - s0), 0);
    check("midcnt_idle", dut.state, IDLE);

    // Game 2: step on a mine at (0,0).
    mine_map = 64'h1; flag_map = '0; step_map = '0;
    start_game("g2");
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check("lose_ld_sm", ld_sm, 1'b1);
    step_map[0] = 1'b1;
    tick(9);
    check("lose_flag", lose, 1'b1);
    check("lose_count", adj_count, 4'd0);
    serve_draw("lose");
    check("lose_state", dut.state, END);
    f0 = cnt_fm; s0 = cnt_sm;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick();
    btn_flag = 1'b1;
    tick();
    btn_flag = 1'b0;
    tick(3);
    check("end_no_strobes", (cnt_fm - f0) + (cnt_sm - s0), 0);
    check("end_state", dut.state, END);
    check("end_lose_sticky", lose, 1'b1);

    // Game 3: everything but cell 63 already stepped; stepping 63 wins.
    mine_map = '0; flag_map = '0; step_map = {1'b0, {63{1'b1}}};
    start_game("g3");
    check("g3_lose_cleared", lose, 1'b0);
    move(DIR_UP);
    move(DIR_LEFT);
    check("cursor_63", cell_idx, 6'd63);
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check("win_ld_sm", ld_sm, 1'b1);
    step_map[63] = 1'b1;
    tick(9);
    check("win_flag", win, 1'b1);
    check("win_lose", lose, 1'b0);
    serve_draw("win");
    check("win_state", dut.state, END);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
